// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_OFFSET  = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Inputs up to 9 map to at most 12, so the 4-bit sum never carries out.
  always_comb begin
    if (din >= ADJ_THRESH) begin
      dout = din + ADJ_OFFSET;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with held BCD digits and an overflow flag for the display stage.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow
);

  localparam int               WORK_W   = BCD_DIGIT_W * DIGITS;
  localparam int               CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t            state_r;
  logic [CNT_W-1:0]  count_r;
  logic [BIN_W-1:0]  shreg_r;
  logic [WORK_W-1:0] work_r;
  logic              ovf_acc_r;
  logic              busy_r;
  logic              done_r;
  logic [WORK_W-1:0] bcd_r;
  logic              ovf_r;

  logic [WORK_W-1:0] adj_s;
  logic [WORK_W-1:0] work_next_s;
  logic [BIN_W-1:0]  shreg_next_s;
  logic              ovf_next_s;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (work_r[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj_s[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // One shift step: corrected digits and shift register move left as one word.
  always_comb begin
    work_next_s  = {adj_s[WORK_W-2:0], shreg_r[BIN_W-1]};
    shreg_next_s = {shreg_r[BIN_W-2:0], 1'b0};
    ovf_next_s   = ovf_acc_r | adj_s[WORK_W-1];
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      count_r   <= {CNT_W{1'b0}};
      shreg_r   <= {BIN_W{1'b0}};
      work_r    <= {WORK_W{1'b0}};
      ovf_acc_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bcd_r     <= {WORK_W{1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            shreg_r   <= bin_in;
            work_r    <= {WORK_W{1'b0}};
            ovf_acc_r <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= SHIFT;
          end
        end
        SHIFT: begin
          work_r    <= work_next_s;
          shreg_r   <= shreg_next_s;
          ovf_acc_r <= ovf_next_s;
          count_r   <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          // Outputs are only ever loaded from the completed post-shift word.
          if (count_r == LAST_CNT) begin
            bcd_r   <= work_next_s;
            ovf_r   <= ovf_next_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          if (start) begin
            shreg_r   <= bin_in;
            work_r    <= {WORK_W{1'b0}};
            ovf_acc_r <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign bcd_out  = bcd_r;
  assign overflow = ovf_r;

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits directly downstream of the ULA result register. It replaces the combinational `%`/`/` digit extraction that feeds the `BCDdecode` display drivers with a small, registered, iterative datapath. It produces a stable, held set of BCD digits plus an overflow flag for the seven-segment stage.

## Interface
- `BIN_W`, default 8: width of the binary input; also the conversion length in shift cycles.
- `DIGITS`, default 3: number of BCD digits produced; 3 covers 0..999.

- `clock` input 1: single system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately when low.
- `start` input 1: request a conversion of `bin_in`; sampled only in IDLE or DONE.
- `bin_in` input `BIN_W`: unsigned value to convert; sampled on the accepting edge only.
- `busy` output 1: high while in SHIFT.
- `done` output 1: one-cycle pulse; `bcd_out`/`overflow` updated in the same cycle.
- `bcd_out` output `4*DIGITS`: digit k occupies bits [4k+3:4k]; digit 0 is the units digit; held between conversions.
- `overflow` output 1: value exceeded 10^DIGITS−1; held with `bcd_out`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `start`=1 → load shift register with `bin_in`, clear work digits, clear overflow accumulator, count=0 → SHIFT.
  - SHIFT: on each edge, the following happens in one cycle:
    - every work digit ≥5 gets +3;
    - then {work digits, shift reg} shifts left by 1; the MSB of the shift reg enters work digit 0 LSB;
    - the bit leaving the top digit's MSB is ORed into the overflow accumulator;
    - count increments.
  - SHIFT exit: on the edge where count = `BIN_W`−1 (the final shift), the post-shift work digits go to `bcd_out`, the accumulator goes to `overflow`, `done` is set to 1, → DONE.
  - DONE: `done` stays high for this one cycle only.
    - `start`=1 → same load as IDLE → SHIFT (back-to-back conversion).
    - otherwise → IDLE.
- `start` in SHIFT is ignored; no queuing.
- `bin_in` changes after the accepting edge do not affect the running conversion.
- `bcd_out` and `overflow` change only on the edge that raises `done`; they never show partial values.
- Digit correction is 4-bit arithmetic. Input ≤9 yields ≤12, so no carry leaves a digit.
- On overflow, `bcd_out` holds the low `DIGITS` digits of the true BCD value.
- Reset (any time, including mid-SHIFT) takes effect asynchronously; the aborted conversion produces no `done`.

## Timing
- Reset values:
  - state=IDLE, `busy`=0, `done`=0, `bcd_out`=0, `overflow`=0;
  - count, work and shift registers = 0.
- Latency: if `start` is accepted at edge E0, `busy` is high from E0 until E`BIN_W`. `done` and the new `bcd_out` are visible from E`BIN_W` for exactly one cycle (8 edges for the default).
- Throughput: with `start` held high, one result every `BIN_W`+1 cycles.
- `busy` and `done` are never high together.

## Structure
- Package `bcd_pkg`:
  - state enum (IDLE/SHIFT/DONE);
  - `BCD_DIGIT_W`=4;
  - correction threshold 5 and offset 3.
- Sub-module `bcd_digit_adj`: combinational 4-bit "if ≥5 add 3". It is instantiated `DIGITS` times in a generate loop.
- Top holds the FSM, counter (width clog2(`BIN_W`)), shift/work registers and output registers.

## Test plan
- Default params, `bin_in`=255, one-cycle `start` → `busy` high 8 cycles, then `done` pulse; `bcd_out`=0x255, `overflow`=0.
- Values 0, 9, 10, 99, 100, 200 → `bcd_out` 0x000, 0x009, 0x010, 0x099, 0x100, 0x200; each `done` exactly 8 edges after its accepting edge.
- `start` pulsed mid-conversion with a different `bin_in` → ignored. The first result (e.g. 0x123 for 123) arrives on schedule; there is exactly one `done`.
- `start` held high with `bin_in`=42 → a `done` every 9 cycles, `bcd_out`=0x042 throughout, no glitch between results.
- `reset` low at shift cycle 4 of a conversion of 77 → outputs zero immediately; no `done` after release; next `start` with 5 → 0x005.
- `BIN_W`=10, `DIGITS`=3: 999 → 0x999 with `overflow`=0; 1023 → `overflow`=1 and `bcd_out`=0x023; 1000 → `overflow`=1 and `bcd_out`=0x000.
